rom_dump_sequencer: RTL and testbench

//  Automatic full-chip reader for the IP3601/IP3604 PROM rig. It walks every address, drives the

---
 rtl/rom_dump_sequencer_if.sv | 56 +++++
 rtl/rom_dump_sequencer.sv | 155 +++++++++++++++
 tb/tb_rom_dump_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_dump_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_dump_sequencer_if
// Purpose  : Bundles the PROM-side bus (address, active-low chip selects,
//            data) together with the byte-stream valid/ready handshake that
//            feeds the downstream byte sink (UART TX).
// Signals  : chip_data      PROM -> sequencer, DATA_WIDTH data lines
//            chip_address   sequencer -> PROM, ADDRESS_WIDTH address lines
//            chip_select_n  sequencer -> PROM, SELECT_WIDTH active-low selects
//            out_data       sequencer -> sink, byte being offered
//            out_valid      sequencer -> sink, out_data valid (held to accept)
//            out_ready      sink -> sequencer, accept strobe
//            out_last       sequencer -> sink, marks the checksum byte
// Modports : master - the sequencer
//            slave  - the PROM rig plus the byte sink
// Revision : 1.0 - initial release
// ============================================================================
interface rom_dump_sequencer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int SELECT_WIDTH  = 4
) ();

  // PROM side
  logic [DATA_WIDTH-1:0]    chip_data;
  logic [ADDRESS_WIDTH-1:0] chip_address;
  logic [SELECT_WIDTH-1:0]  chip_select_n;

  // Byte stream side
  logic [7:0]               out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    input  chip_data,
    output chip_address,
    output chip_select_n,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    output chip_data,
    input  chip_address,
    input  chip_select_n,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/rom_dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rom_dump_sequencer
// Purpose  : Automatic full-chip reader for the IP3601/IP3604 PROM rig.
//            Walks every address 0..2^ADDRESS_WIDTH-1, asserts the chip
//            selects, waits SETTLE_CYCLES for the data to settle, samples it
//            and streams one zero-extended byte per address to a byte sink.
//            An 8-bit additive checksum byte (out_last=1) closes the dump.
// Ports    : clk      in   board clock, rising edge
//            reset_n  in   synchronous active-low reset
//            start    in   begins a dump when idle (pulse or level)
//            abort    in   ends a dump in progress, no checksum, no done
//            bus      if   rom_dump_sequencer_if.master (PROM bus + stream)
//            busy     out  high from the cycle after start until idle again
//            done     out  one-cycle pulse after the checksum is accepted
// Params   : DATA_WIDTH, ADDRESS_WIDTH, SELECT_WIDTH must match the widths
//            of the connected interface instance.
// Revision : 1.0 - initial release
// ============================================================================
module rom_dump_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int SELECT_WIDTH  = 4,
  parameter int SETTLE_CYCLES = 50
) (
  input  wire                   clk,
  input  wire                   reset_n,
  input  wire                   start,
  input  wire                   abort,
  rom_dump_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done
);

  // Settle counter spans 0..SETTLE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]         SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST   = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_SEND   = 3'd3,
    ST_CHKSUM = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [7:0]       checksum;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      settle_cnt        <= '0;
      checksum          <= 8'h00;
      bus.chip_address  <= '0;
      bus.chip_select_n <= '1;
      bus.out_data      <= 8'h00;
      bus.out_valid     <= 1'b0;
      bus.out_last      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else if (abort && (state != ST_IDLE)) begin
      // Abort has priority over the handshake: a byte being accepted in
      // this very cycle is still dropped and no checksum follows.
      state             <= ST_IDLE;
      settle_cnt        <= '0;
      bus.chip_select_n <= '1;
      bus.out_valid     <= 1'b0;
      bus.out_last      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // abort in IDLE blocks a simultaneous start.
          if (start && !abort) begin
            state             <= ST_SETTLE;
            settle_cnt        <= '0;
            checksum          <= 8'h00;
            bus.chip_address  <= '0;
            bus.chip_select_n <= '0;
            busy              <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          // Narrow PROMs are zero-extended to a full byte.
          bus.out_data  <= 8'(bus.chip_data);
          bus.out_valid <= 1'b1;
          state         <= ST_SEND;
        end

        ST_SEND: begin
          // out_valid is high throughout SEND; everything holds while the
          // sink stalls.
          if (bus.out_ready) begin
            checksum <= checksum + bus.out_data;
            if (bus.chip_address == ADDR_LAST) begin
              // Terminal address: no wrap. The checksum byte (including the
              // byte just accepted) is presented straight away.
              state             <= ST_CHKSUM;
              bus.out_data      <= checksum + bus.out_data;
              bus.out_last      <= 1'b1;
              bus.chip_select_n <= '1;
            end else begin
              // The only point where the address moves, so it is stable
              // across the whole settle and sample window.
              state            <= ST_SETTLE;
              settle_cnt       <= '0;
              bus.out_valid    <= 1'b0;
              bus.chip_address <= bus.chip_address + ADDRESS_WIDTH'(1);
            end
          end
        end

        ST_CHKSUM: begin
          if (bus.out_ready) begin
            state         <= ST_DONE;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state             <= ST_IDLE;
          bus.chip_select_n <= '1;
          bus.out_valid     <= 1'b0;
          bus.out_last      <= 1'b0;
          busy              <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_dump_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rom_dump_sequencer
// Purpose  : Self-checking bench. A small instance (AW=2, DW=4, settle=3)
//            covers streaming, stalls, abort, reset and start handling; a
//            full-size instance (AW=9, DW=8, settle=50) covers a whole chip.
//            Expected streams come from a ROM array plus a running sum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_dump_sequencer;

  localparam int S_SETTLE = 3;
  localparam int B_SETTLE = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // ---------------- small instance ----------------
  logic s_reset_n, s_start, s_abort, s_busy, s_done;
  logic [3:0] s_rom [4];
  rom_dump_sequencer_if #(.DATA_WIDTH(4), .ADDRESS_WIDTH(2), .SELECT_WIDTH(2)) s_bus ();
  assign s_bus.chip_data = (s_bus.chip_select_n == 2'b00) ? s_rom[s_bus.chip_address] : 4'h0;

  rom_dump_sequencer #(.DATA_WIDTH(4), .ADDRESS_WIDTH(2), .SELECT_WIDTH(2),
                       .SETTLE_CYCLES(S_SETTLE)) s_dut (
    .clk(clk), .reset_n(s_reset_n), .start(s_start), .abort(s_abort),
    .bus(s_bus.master), .busy(s_busy), .done(s_done));

  // ---------------- full-size instance ----------------
  logic b_reset_n, b_start, b_abort, b_busy, b_done;
  rom_dump_sequencer_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(9), .SELECT_WIDTH(4)) b_bus ();
  assign b_bus.chip_data = (b_bus.chip_select_n == 4'h0) ? b_bus.chip_address[7:0] : 8'h00;

  rom_dump_sequencer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(9), .SELECT_WIDTH(4),
                       .SETTLE_CYCLES(B_SETTLE)) b_dut (
    .clk(clk), .reset_n(b_reset_n), .start(b_start), .abort(b_abort),
    .bus(b_bus.master), .busy(b_busy), .done(b_done));

  // ---------------- sink monitors ----------------
  logic [7:0] s_q[$];  bit s_lq[$];  int s_tq[$];  int s_aq[$];  int s_done_cnt = 0;
  logic [7:0] b_q[$];  bit b_lq[$];  int b_tq[$];  int b_done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_bus.out_valid && s_bus.out_ready) begin
      s_q.push_back(s_bus.out_data);
      s_lq.push_back(s_bus.out_last);
      s_tq.push_back(cyc);
      s_aq.push_back(int'(s_bus.chip_address));
    end
    if (b_bus.out_valid && b_bus.out_ready) begin
      b_q.push_back(b_bus.out_data);
      b_lq.push_back(b_bus.out_last);
      b_tq.push_back(cyc);
    end
    if (s_done) s_done_cnt <= s_done_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] s_get(int idx);
    if (idx < s_q.size()) return {s_lq[idx], s_q[idx]};
    return 9'bx;
  endfunction

  function automatic int s_time(int idx);
    if (idx < s_tq.size()) return s_tq[idx];
    return -1000;
  endfunction

  // Reference: 4 data bytes then {last, sum mod 256}.
  function automatic logic [8:0] s_model(int idx);
    logic [7:0] sum;
    sum = 8'h00;
    for (int a = 0; a < 4; a++) sum = sum + 8'(s_rom[a]);
    if (idx < 4) return {1'b0, 8'(s_rom[idx])};
    return {1'b1, sum};
  endfunction

  task automatic set_fixed_rom();
    s_rom[0] = 4'h3; s_rom[1] = 4'hA; s_rom[2] = 4'hF; s_rom[3] = 4'h1;
  endtask

  task automatic run_dump_s(output int t0, output bit timed_out);
    t0 = cyc;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (s_done) begin timed_out = 1'b0; break; end
      tick();
    end
    tick(); tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    s_reset_n = 1'b0; s_start = 1'b1; s_abort = 1'b0; s_bus.out_ready = 1'b1;
    b_reset_n = 1'b0; b_start = 1'b1; b_abort = 1'b0; b_bus.out_ready = 1'b1;
    set_fixed_rom();
    repeat (3) tick();
    checks++; if (s_bus.chip_address !== 2'd0) $display("FAIL reset_addr: got %0h want 0", s_bus.chip_address); else passed++;
    checks++; if (s_bus.chip_select_n !== 2'b11) $display("FAIL reset_cs: got %b want 11", s_bus.chip_select_n); else passed++;
    checks++; if (s_bus.out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", s_bus.out_data); else passed++;
    checks++; if (s_bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", s_bus.out_valid); else passed++;
    checks++; if (s_bus.out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", s_bus.out_last); else passed++;
    checks++; if (s_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", s_busy); else passed++;
    checks++; if (s_done !== 1'b0) $display("FAIL reset_done: got %b want 0", s_done); else passed++;
    checks++; if ({b_busy, b_bus.out_valid, b_bus.chip_select_n} !== 6'b00_1111)
      $display("FAIL reset_big: got %b want 001111", {b_busy, b_bus.out_valid, b_bus.chip_select_n}); else passed++;
    s_start = 1'b0; b_start = 1'b0;
    tick();
    s_reset_n = 1'b1; b_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int t0, base, dbase; bit to;
    set_fixed_rom();
    s_bus.out_ready = 1'b1;
    base = s_q.size(); dbase = s_done_cnt;
    run_dump_s(t0, to);
    checks++; if (to) $display("FAIL basic_timeout: got no done want done"); else passed++;
    checks++; if (s_q.size() - base !== 5) $display("FAIL basic_count: got %0d want 5", s_q.size() - base); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_get(base + i) !== s_model(i)) $display("FAIL basic_byte%0d: got %h want %h", i, s_get(base + i), s_model(i)); else passed++;
    end
    checks++; if (s_time(base) - t0 !== S_SETTLE + 2) $display("FAIL basic_latency: got %0d want %0d", s_time(base) - t0, S_SETTLE + 2); else passed++;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (s_time(base + i) - s_time(base + i - 1) !== S_SETTLE + 2)
        $display("FAIL basic_spacing%0d: got %0d want %0d", i, s_time(base + i) - s_time(base + i - 1), S_SETTLE + 2); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (base + i >= s_aq.size() || s_aq[base + i] !== i)
        $display("FAIL basic_addr%0d: got %0d want %0d", i, (base + i < s_aq.size()) ? s_aq[base + i] : -1, i); else passed++;
    end
    checks++; if (s_done_cnt - dbase !== 1) $display("FAIL basic_done: got %0d pulses want 1", s_done_cnt - dbase); else passed++;
    checks++; if ({s_busy, s_bus.chip_select_n} !== 3'b011) $display("FAIL basic_idle: got %b want 011", {s_busy, s_bus.chip_select_n}); else passed++;
  endtask

  task automatic test_stall();
    int base, dbase, bad; bit to;
    set_fixed_rom();
    s_bus.out_ready = 1'b1;
    base = s_q.size(); dbase = s_done_cnt;
    s_start = 1'b1; tick(); s_start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (s_q.size() - base >= 1) begin to = 1'b0; break; end
      tick();
    end
    s_bus.out_ready = 1'b0;
    for (int c = 0; c < 50 && !s_bus.out_valid; c++) tick();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (s_bus.out_valid !== 1'b1 || s_bus.out_data !== 8'h0A || s_bus.chip_address !== 2'd1 ||
          s_bus.out_last !== 1'b0 || s_bus.chip_select_n !== 2'b00) bad++;
      tick();
    end
    checks++; if (to || bad != 0) $display("FAIL stall_hold: got %0d bad cycles (timeout %0d) want 0", bad, to); else passed++;
    checks++; if (s_q.size() - base !== 1) $display("FAIL stall_no_accept: got %0d accepted want 1", s_q.size() - base); else passed++;
    s_bus.out_ready = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (s_done) begin to = 1'b0; break; end
      tick();
    end
    tick(); tick();
    checks++; if (to) $display("FAIL stall_timeout: got no done want done"); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_get(base + i) !== s_model(i)) $display("FAIL stall_byte%0d: got %h want %h", i, s_get(base + i), s_model(i)); else passed++;
    end
    checks++; if (s_time(base + 2) - s_time(base + 1) !== S_SETTLE + 2)
      $display("FAIL stall_resume_spacing: got %0d want %0d", s_time(base + 2) - s_time(base + 1), S_SETTLE + 2); else passed++;
    checks++; if (s_done_cnt - dbase !== 1) $display("FAIL stall_done: got %0d want 1", s_done_cnt - dbase); else passed++;
  endtask

  task automatic test_abort();
    int t0, base, dbase, lasts; bit to;
    set_fixed_rom();
    s_bus.out_ready = 1'b1;
    base = s_q.size(); dbase = s_done_cnt;
    s_start = 1'b1; tick(); s_start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (s_bus.out_valid && s_bus.chip_address == 2'd2) begin to = 1'b0; break; end
      tick();
    end
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
    checks++; if (to) $display("FAIL abort_reach_send2: got timeout want SEND of address 2"); else passed++;
    checks++; if ({s_bus.out_valid, s_bus.out_last, s_busy, s_bus.chip_select_n} !== 5'b000_11)
      $display("FAIL abort_state: got valid/last/busy/cs %b want 00011", {s_bus.out_valid, s_bus.out_last, s_busy, s_bus.chip_select_n}); else passed++;
    repeat (8) tick();
    lasts = 0;
    for (int i = base; i < s_q.size(); i++) if (s_lq[i]) lasts++;
    checks++; if (lasts != 0 || s_q.size() - base > 3) $display("FAIL abort_no_checksum: got %0d last bytes, %0d bytes want 0, <=3", lasts, s_q.size() - base); else passed++;
    checks++; if ({s_get(base), s_get(base + 1)} !== {s_model(0), s_model(1)})
      $display("FAIL abort_prefix: got %h %h want %h %h", s_get(base), s_get(base + 1), s_model(0), s_model(1)); else passed++;
    checks++; if (s_done_cnt - dbase !== 0 || s_busy !== 1'b0) $display("FAIL abort_done: got %0d pulses busy %b want 0 0", s_done_cnt - dbase, s_busy); else passed++;
    base = s_q.size(); dbase = s_done_cnt;
    run_dump_s(t0, to);
    checks++; if (to) $display("FAIL abort_rerun_timeout: got no done want done"); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_get(base + i) !== s_model(i)) $display("FAIL abort_rerun_byte%0d: got %h want %h", i, s_get(base + i), s_model(i)); else passed++;
    end
    checks++; if (s_done_cnt - dbase !== 1) $display("FAIL abort_rerun_done: got %0d want 1", s_done_cnt - dbase); else passed++;
  endtask

  task automatic test_reset_mid();
    int t0, base, dbase; bit to;
    set_fixed_rom();
    s_bus.out_ready = 1'b1;
    s_start = 1'b1; tick(); s_start = 1'b0;
    tick();
    checks++; if ({s_busy, s_bus.chip_select_n} !== 3'b100) $display("FAIL midreset_pre: got %b want 100", {s_busy, s_bus.chip_select_n}); else passed++;
    s_reset_n = 1'b0;
    tick();
    s_reset_n = 1'b1;
    checks++; if ({s_bus.chip_address, s_bus.chip_select_n, s_bus.out_data, s_bus.out_valid, s_bus.out_last, s_busy, s_done} !== {2'd0, 2'b11, 8'h00, 4'b0000})
      $display("FAIL midreset_outputs: got %h want %h", {s_bus.chip_address, s_bus.chip_select_n, s_bus.out_data, s_bus.out_valid, s_bus.out_last, s_busy, s_done}, {2'd0, 2'b11, 8'h00, 4'b0000}); else passed++;
    repeat (6) tick();
    checks++; if ({s_busy, s_bus.out_valid} !== 2'b00) $display("FAIL midreset_stays_idle: got %b want 00", {s_busy, s_bus.out_valid}); else passed++;
    // start together with abort in IDLE must not begin a dump.
    s_start = 1'b1; s_abort = 1'b1; tick(); s_start = 1'b0; s_abort = 1'b0; tick();
    checks++; if ({s_busy, s_bus.chip_select_n} !== 3'b011) $display("FAIL start_abort_idle: got %b want 011", {s_busy, s_bus.chip_select_n}); else passed++;
    // Random start pulses while busy must not disturb the stream.
    base = s_q.size(); dbase = s_done_cnt;
    t0 = cyc;
    s_start = 1'b1; tick();
    to = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (s_done) begin to = 1'b0; break; end
      s_start = s_busy && ($urandom_range(0, 2) == 0);
      tick();
    end
    s_start = 1'b0;
    tick(); tick();
    checks++; if (to) $display("FAIL busy_start_timeout: got no done want done"); else passed++;
    checks++; if (s_time(base) - t0 !== S_SETTLE + 2) $display("FAIL busy_start_latency: got %0d want %0d", s_time(base) - t0, S_SETTLE + 2); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_get(base + i) !== s_model(i)) $display("FAIL busy_start_byte%0d: got %h want %h", i, s_get(base + i), s_model(i)); else passed++;
    end
    checks++; if (s_q.size() - base !== 5 || s_done_cnt - dbase !== 1)
      $display("FAIL busy_start_count: got %0d bytes %0d done want 5 1", s_q.size() - base, s_done_cnt - dbase); else passed++;
  endtask

  task automatic test_random_backpressure();
    for (int it = 0; it < 4; it++) begin
      int base, dbase, unstable;
      bit finished, pend;
      logic [7:0] pd; logic pl; logic [1:0] pa;
      for (int a = 0; a < 4; a++) s_rom[a] = 4'($urandom_range(0, 15));
      base = s_q.size(); dbase = s_done_cnt; unstable = 0; finished = 1'b0;
      s_start = 1'b1; tick(); s_start = 1'b0;
      for (int c = 0; c < 600 && !finished; c++) begin
        s_bus.out_ready = ($urandom_range(0, 2) != 0);
        pend = s_bus.out_valid && !s_bus.out_ready;
        pd = s_bus.out_data; pl = s_bus.out_last; pa = s_bus.chip_address;
        tick();
        if (pend && (s_bus.out_valid !== 1'b1 || s_bus.out_data !== pd ||
                     s_bus.out_last !== pl || s_bus.chip_address !== pa)) unstable++;
        if (s_done) finished = 1'b1;
      end
      s_bus.out_ready = 1'b1;
      tick(); tick();
      checks++; if (!finished || unstable != 0) $display("FAIL rand%0d_stall_stable: got %0d unstable (finished %0d) want 0", it, unstable, finished); else passed++;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (s_get(base + i) !== s_model(i)) $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, s_get(base + i), s_model(i)); else passed++;
      end
      checks++; if (s_q.size() - base !== 5 || s_done_cnt - dbase !== 1)
        $display("FAIL rand%0d_count: got %0d bytes %0d done want 5 1", it, s_q.size() - base, s_done_cnt - dbase); else passed++;
    end
  endtask

  task automatic test_full_chip();
    int t0, base, dbase, bad, gapbad, first;
    bit to;
    logic [7:0] sum;
    logic [8:0] want, got;
    b_bus.out_ready = 1'b1;
    base = b_q.size(); dbase = b_done_cnt;
    t0 = cyc;
    b_start = 1'b1; tick(); b_start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 30000; c++) begin
      if (b_done) begin to = 1'b0; break; end
      tick();
    end
    tick(); tick();
    checks++; if (to) $display("FAIL full_timeout: got no done want done"); else passed++;
    checks++; if (b_q.size() - base !== 513) $display("FAIL full_count: got %0d want 513", b_q.size() - base); else passed++;
    sum = 8'h00; bad = 0;
    for (int i = 0; i < 513; i++) begin
      if (i < 512) begin want = {1'b0, 8'(i % 256)}; sum = sum + 8'(i % 256); end
      else want = {1'b1, sum};
      got = (base + i < b_q.size()) ? {b_lq[base + i], b_q[base + i]} : 9'bx;
      if (got !== want) bad++;
    end
    checks++; if (bad != 0) $display("FAIL full_stream: got %0d wrong bytes want 0", bad); else passed++;
    got = (base + 512 < b_q.size()) ? {b_lq[base + 512], b_q[base + 512]} : 9'bx;
    checks++; if (got !== 9'h100) $display("FAIL full_checksum: got %h want 100", got); else passed++;
    first = (base < b_tq.size()) ? b_tq[base] - t0 : -1;
    checks++; if (first !== B_SETTLE + 2) $display("FAIL full_latency: got %0d want %0d", first, B_SETTLE + 2); else passed++;
    gapbad = 0;
    for (int i = 1; i < 512; i++)
      if (base + i >= b_tq.size() || b_tq[base + i] - b_tq[base + i - 1] != B_SETTLE + 2) gapbad++;
    checks++; if (gapbad != 0) $display("FAIL full_spacing: got %0d bad gaps want 0", gapbad); else passed++;
    checks++; if (b_done_cnt - dbase !== 1) $display("FAIL full_done: got %0d want 1", b_done_cnt - dbase); else passed++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random_backpressure();
    test_full_chip();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
